ff_delay_line: RTL and testbench

FF_DELAY_LINE -- requirements
Module: ff_delay_line

---
 rtl/ff_delay_line.sv | 84 ++++++++
 tb/tb_ff_delay_line.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ff_delay_line.sv
// ---------------------------------------------------------------------------
// ff_delay_line
//   Parameterised register delay line with a valid flag per stage and a
//   running count of how many stages currently hold valid data.
//
// Parameters
//   WIDTH     : data bits per stage (1..64)
//   DEPTH     : number of register stages (1..16)
//   RESET_VAL : value loaded into every data stage on reset and on clear
//   HOLD_Q    : 0 = plain shift, 1 = data stages load only valid words
//
// Ports
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   en        : clock enable, pipeline advances only when high
//   clr       : synchronous clear, has priority over en
//   d         : data into stage 0
//   d_valid   : qualifies d
//   q         : data from the last stage (registered)
//   q_valid   : valid flag of the last stage (registered)
//   valid_cnt : number of stages currently holding valid data (registered)
// ---------------------------------------------------------------------------
module ff_delay_line #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               HOLD_Q    = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       clr,
  input  logic [WIDTH-1:0]           d,
  input  logic                       d_valid,
  output logic [WIDTH-1:0]           q,
  output logic                       q_valid,
  output logic [$clog2(DEPTH+1)-1:0] valid_cnt
);

  localparam int               CNT_W   = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam bit               HOLD    = (HOLD_Q != 0);

  logic [WIDTH-1:0] r_stage [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [CNT_W-1:0] r_cnt;

  logic w_cnt_inc;
  logic w_cnt_dec;

  // A word entering while none leaves grows the count, and the reverse shrinks
  // it; entering and leaving on the same edge leaves it unchanged. Because the
  // count tracks the flags exactly it can never overflow or underflow.
  assign w_cnt_inc = d_valid & ~r_vld[DEPTH-1];
  assign w_cnt_dec = ~d_valid & r_vld[DEPTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) r_stage[k] <= RESET_VAL;
      r_vld <= '0;
      r_cnt <= '0;
    end else if (clr) begin
      for (int k = 0; k < DEPTH; k++) r_stage[k] <= RESET_VAL;
      r_vld <= '0;
      r_cnt <= '0;
    end else if (en) begin
      // In hold mode a stage only takes a word that is marked valid, so each
      // stage keeps the most recent valid word that has reached it.
      if (!HOLD || d_valid) r_stage[0] <= d;
      for (int k = 1; k < DEPTH; k++) begin
        if (!HOLD || r_vld[k-1]) r_stage[k] <= r_stage[k-1];
      end
      r_vld[0] <= d_valid;
      for (int k = 1; k < DEPTH; k++) r_vld[k] <= r_vld[k-1];
      if (w_cnt_inc)      r_cnt <= r_cnt + CNT_ONE;
      else if (w_cnt_dec) r_cnt <= r_cnt - CNT_ONE;
    end
  end

  assign q         = r_stage[DEPTH-1];
  assign q_valid   = r_vld[DEPTH-1];
  assign valid_cnt = r_cnt;

endmodule

// File: tb/tb_ff_delay_line.sv
// ---------------------------------------------------------------------------
// tb_ff_delay_line
//   Drives three delay-line configurations from one shared input stream:
//     A : DEPTH=4, plain shift, RESET_VAL=0x00
//     B : DEPTH=4, hold mode,   RESET_VAL=0x3C
//     C : DEPTH=1, plain shift, RESET_VAL=0x96
//   The reference model keeps the list of words sampled on enabled edges
//   since the last reset/clear and derives each configuration's outputs from
//   that history. Expected outputs are queued per cycle by the driver and
//   compared by an independent monitor on the falling edge.
// ---------------------------------------------------------------------------
module tb_ff_delay_line;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic [7:0] d;
  logic       d_valid;

  logic [7:0] q_a, q_b, q_c;
  logic       qv_a, qv_b, qv_c;
  logic [2:0] cnt_a, cnt_b;
  logic [0:0] cnt_c;

  always #5 clk = ~clk;

  ff_delay_line #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00), .HOLD_Q(0)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .d(d), .d_valid(d_valid),
    .q(q_a), .q_valid(qv_a), .valid_cnt(cnt_a));

  ff_delay_line #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h3C), .HOLD_Q(1)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .d(d), .d_valid(d_valid),
    .q(q_b), .q_valid(qv_b), .valid_cnt(cnt_b));

  ff_delay_line #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h96), .HOLD_Q(0)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .d(d), .d_valid(d_valid),
    .q(q_c), .q_valid(qv_c), .valid_cnt(cnt_c));

  typedef struct {
    logic [7:0] d;
    logic       v;
  } samp_t;

  typedef struct {
    logic [7:0] qa, qb, qc;
    logic       va, vb, vc;
    logic [7:0] ca, cb, cc;
  } exp_t;

  samp_t hist[$];
  exp_t  exq[$];
  int    checks = 0;
  int    errors = 0;

  // ---------------- reference model ----------------
  // q of a DEPTH-stage line is the word sampled DEPTH enabled edges ago; in
  // hold mode it is the newest valid word at least DEPTH edges old.
  function automatic logic [7:0] m_q(int depth, bit hold, logic [7:0] rv);
    int n = hist.size();
    logic [7:0] r = rv;
    if (!hold) begin
      if (n >= depth) r = hist[n-depth].d;
    end else begin
      for (int i = 0; i <= n - depth; i++)
        if (hist[i].v) r = hist[i].d;
    end
    return r;
  endfunction

  function automatic logic m_v(int depth);
    int n = hist.size();
    return (n >= depth) ? hist[n-depth].v : 1'b0;
  endfunction

  function automatic int m_c(int depth);
    int n = hist.size();
    int c = 0;
    for (int i = (n > depth ? n - depth : 0); i < n; i++)
      if (hist[i].v) c++;
    return c;
  endfunction

  task automatic push_expect();
    exp_t e;
    e.qa = m_q(4, 1'b0, 8'h00);  e.va = m_v(4);  e.ca = 8'(m_c(4));
    e.qb = m_q(4, 1'b1, 8'h3C);  e.vb = m_v(4);  e.cb = 8'(m_c(4));
    e.qc = m_q(1, 1'b0, 8'h96);  e.vc = m_v(1);  e.cc = 8'(m_c(1));
    exq.push_back(e);
  endtask

  // ---------------- monitor ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exq.size() > 0) begin
      exp_t e;
      e = exq.pop_front();
      chk("A.q",         q_a,          e.qa);
      chk("A.q_valid",   8'(qv_a),     8'(e.va));
      chk("A.valid_cnt", 8'(cnt_a),    e.ca);
      chk("B.q",         q_b,          e.qb);
      chk("B.q_valid",   8'(qv_b),     8'(e.vb));
      chk("B.valid_cnt", 8'(cnt_b),    e.cb);
      chk("C.q",         q_c,          e.qc);
      chk("C.q_valid",   8'(qv_c),     8'(e.vc));
      chk("C.valid_cnt", 8'(cnt_c),    e.cc);
    end
  end

  // ---------------- driver ----------------
  // Apply inputs for the coming edge, let it happen, advance the model, queue
  // the expectation. With rpulse, reset is pulsed low after the edge and held
  // across the falling edge so the monitor sees the asynchronous clear.
  task automatic step(input logic e, input logic c, input logic [7:0] dd,
                      input logic dv, input bit rpulse);
    en = e; clr = c; d = dd; d_valid = dv;
    @(posedge clk);
    if (!rst_n)      hist.delete();
    else if (c)      hist.delete();
    else if (e)      hist.push_back('{dd, dv});
    #1;
    if (rpulse) begin
      rst_n = 1'b0;
      hist.delete();
    end
    push_expect();
    if (rpulse) begin
      @(negedge clk);
      #1 rst_n = 1'b1;
    end
  endtask

  task automatic stream(input logic [7:0] first, input int n);
    logic [7:0] w = first;
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, w, 1'b1, 1'b0);
      w = w + 8'h11;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; d = 8'h00; d_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    hist.delete();
    push_expect();

    // Basic stream: 0x11..0x88, then drain with invalid data.
    stream(8'h11, 8);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'hE0 + 8'(i), 1'b0, 1'b0);

    // Enable toggling 1,0,1,0 during a stream.
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++)
      step(i[0] ? 1'b0 : 1'b1, 1'b0, 8'h11 * 8'((i / 2) + 1), 1'b1, 1'b0);

    // Clear while full with en=1 and d_valid=1; then clear with en=0.
    stream(8'h11, 4);
    step(1'b1, 1'b1, 8'h99, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'h77, 1'b1, 1'b0);
    stream(8'h22, 3);
    step(1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h55, 1'b1, 1'b0);

    // Hold mode: one valid 0xA5 followed by invalid 0xFF words.
    step(1'b1, 1'b0, 8'hA5, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);

    // Async reset pulse with 0x11..0x44 in flight, then clean restart.
    stream(8'h11, 4);
    step(1'b1, 1'b0, 8'h55, 1'b1, 1'b1);
    stream(8'h11, 6);

    // Randomised traffic, including occasional clears and reset pulses.
    for (int i = 0; i < 1200; i++) begin
      logic re, rc, rv;
      bit   rp;
      re = ($urandom_range(0, 3) != 0);
      rc = ($urandom_range(0, 39) == 0);
      rv = $urandom_range(0, 1) != 0;
      rp = ($urandom_range(0, 149) == 0);
      step(re, rc, 8'($urandom), rv, rp);
    end

    @(negedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
